// File: rtl/cacheline_adapter.sv
// -----------------------------------------------------------------------------
// cacheline_adapter
//
// Bridges the cache's memory-side (dfp) port to the banked memory (bmem)
// interface. A 256-bit line writeback is serialised into a 4-beat 64-bit write
// burst (beat 0 = lowest bits); a line fill issues a single-cycle read request
// and gathers 4 returned beats into one line. Each line transaction completes
// with a single-cycle dfp_resp.
//
// Ports
//   clk          clock
//   rst          synchronous active-low reset (0 = reset)
//   dfp_addr     line address from cache (offset bits ignored)
//   dfp_read     line fill request, held until dfp_resp
//   dfp_write    line writeback request, held until dfp_resp
//   dfp_wdata    writeback line
//   dfp_rdata    fill line, valid when dfp_resp=1, held until next fill ends
//   dfp_resp     one-cycle completion pulse
//   bmem_addr    line-aligned burst address
//   bmem_read    read burst request (one accepted cycle)
//   bmem_write   write beat valid
//   bmem_wdata   write beat data
//   bmem_ready   memory accepts request/beat this cycle
//   bmem_rdata   read beat data
//   bmem_rvalid  read beat valid
// -----------------------------------------------------------------------------
module cacheline_adapter #(
  parameter int LINE_BITS   = 256,
  parameter int BEAT_BITS   = 64,
  parameter int OFFSET_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_BITS-1:0] dfp_wdata,
  output logic [LINE_BITS-1:0] dfp_rdata,
  output logic                 dfp_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  localparam int BEATS    = LINE_BITS / BEAT_BITS;
  localparam int CNT_BITS = $clog2(BEATS);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(BEATS - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [LINE_BITS-1:0] wline_q, wline_d;
  logic [LINE_BITS-1:0] rline_q, rline_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic                 resp_q, resp_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [BEAT_BITS-1:0] wdata_q, wdata_d;
  logic [31:0]          aligned_addr_s;

  // Offset bits never leave the block: the outgoing address is line aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dfp_addr[OFFSET_BITS-1:0];
  assign aligned_addr_s   = {dfp_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  // Next-state, beat counter, line buffers and next values of the output registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        // Write wins over a simultaneous read; the cache re-presents the read.
        if (dfp_write) begin
          state_d = S_WR;
          cnt_d   = '0;
          addr_d  = aligned_addr_s;
          wline_d = dfp_wdata;
        end else if (dfp_read) begin
          state_d = S_RD_REQ;
          addr_d  = aligned_addr_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WR;
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_RD_REQ: begin
        if (bmem_ready) begin
          state_d = S_RD_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_WAIT: begin
        if (bmem_rvalid) begin
          rline_d[int'(cnt_q) * BEAT_BITS +: BEAT_BITS] = bmem_rdata;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            // Publish the assembled line together with the response pulse.
            state_d = S_RESP;
            rdata_d = rline_d;
          end else begin
            state_d = S_RD_WAIT;
          end
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Output registers are loaded from next-state so they line up with the state.
    resp_d  = (state_d == S_RESP);
    rd_d    = (state_d == S_RD_REQ);
    wr_d    = (state_d == S_WR);
    wdata_d = wline_d[int'(cnt_d) * BEAT_BITS +: BEAT_BITS];
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign dfp_rdata  = rdata_q;
  assign dfp_resp   = resp_q;
  assign bmem_addr  = addr_q;
  assign bmem_read  = rd_q;
  assign bmem_write = wr_q;
  assign bmem_wdata = wdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adapter
//
// Directed bench for cacheline_adapter. The bench plays both the cache (dfp
// side) and the memory (bmem side). Outputs are sampled 1 time unit after the
// rising edge; inputs for the next edge are driven at the same point.
// -----------------------------------------------------------------------------
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] W1 = 256'h0123456789abcdef_fedcba9876543210_0011223344556677_8899aabbccddeeff;
  localparam logic [255:0] W2 = 256'h1111111111111111_2222222222222222_3333333333333333_4444444444444444;
  localparam logic [255:0] W3 = 256'hcafe0000cafe0003_cafe0000cafe0002_cafe0000cafe0001_cafe0000cafe0000;
  localparam logic [255:0] R1 = 256'hdddddddddddd0003_cccccccccccc0002_bbbbbbbbbbbb0001_aaaaaaaaaaaa0000;
  localparam logic [255:0] R2 = 256'h0f0f0f0f0f0f0f0f_1e1e1e1e1e1e1e1e_2d2d2d2d2d2d2d2d_3c3c3c3c3c3c3c3c;
  localparam logic [255:0] R3 = 256'h5555000000000033_5555000000000022_5555000000000011_5555000000000000;
  localparam logic [255:0] R4 = 256'h7777777700000004_6666666600000003_5555555500000002_4444444400000001;

  cacheline_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One writeback: optional stall of stall_len cycles before beat stall_beat,
  // optional stray bmem_rvalid every cycle. exp_resp counts cycles after accept.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [255:0] line,
                          input int stall_beat, input int stall_len, input bit stray,
                          input int exp_resp, input logic [255:0] prev);
    int beat;
    int resp_at;
    int left;
    bit rdy;
    beat = 0; resp_at = -1; left = stall_len; rdy = 1'b1;
    dfp_write = 1'b1; dfp_addr = a; dfp_wdata = line; bmem_ready = 1'b1;
    tick();
    // Only the latched copies may be used after accept.
    dfp_addr = ~a; dfp_wdata = ~line;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (dfp_resp === 1'b1) begin
        resp_at = cyc;
        break;
      end
      if (beat < 4) begin
        chk({tag, "_wr"}, bmem_write, 1);
        chk({tag, "_addr"}, bmem_addr, {a[31:5], 5'b00000});
        chk({tag, "_wdata"}, bmem_wdata, line[beat*64 +: 64]);
      end
      chk({tag, "_rdata_hold"}, dfp_rdata, prev);
      rdy = 1'b1;
      if (beat == stall_beat && left > 0) begin
        rdy = 1'b0;
        left--;
      end
      bmem_ready  = rdy;
      bmem_rvalid = stray;
      bmem_rdata  = 64'hdead_beef_dead_beef;
      tick();
      if (rdy && beat < 4) beat++;
    end
    bmem_ready = 1'b1; bmem_rvalid = 1'b0;
    chk({tag, "_resp_cycle"}, resp_at, exp_resp);
    chk({tag, "_beats"}, beat, 4);
    chk({tag, "_wr_off"}, bmem_write, 0);
    chk({tag, "_rdata_keep"}, dfp_rdata, prev);
    dfp_write = 1'b0; dfp_read = 1'b0;
    tick();
    chk({tag, "_resp_pulse"}, dfp_resp, 0);
    chk({tag, "_wr_idle"}, bmem_write, 0);
  endtask

  // One fill: pat bit i gives bmem_rvalid for the i-th cycle after the request is granted.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [255:0] line,
                         input logic [15:0] pat, input int exp_resp, input logic [255:0] prev);
    int beat;
    int idx;
    int reqs;
    int resp_at;
    bit granted;
    beat = 0; idx = 0; reqs = 0; resp_at = -1; granted = 1'b0;
    dfp_read = 1'b1; dfp_addr = a; bmem_ready = 1'b1; bmem_rvalid = 1'b0;
    tick();
    dfp_addr = ~a;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (dfp_resp === 1'b1) begin
        resp_at = cyc;
        break;
      end
      chk({tag, "_addr"}, bmem_addr, {a[31:5], 5'b00000});
      chk({tag, "_rdata_hold"}, dfp_rdata, prev);
      bmem_rvalid = 1'b0;
      bmem_rdata  = 64'hbad0_bad0_bad0_bad0;
      if (bmem_read === 1'b1) begin
        reqs++;
        granted = 1'b1;
      end else if (granted) begin
        if (idx < 16 && pat[idx] && beat < 4) begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = line[beat*64 +: 64];
          beat++;
        end
        idx++;
      end
      tick();
    end
    bmem_rvalid = 1'b0;
    chk({tag, "_resp_cycle"}, resp_at, exp_resp);
    chk({tag, "_read_cycles"}, reqs, 1);
    chk({tag, "_line"}, dfp_rdata, line);
    chk({tag, "_rd_off"}, bmem_read, 0);
    dfp_read = 1'b0;
    tick();
    chk({tag, "_resp_pulse"}, dfp_resp, 0);
    chk({tag, "_line_keep"}, dfp_rdata, line);
  endtask

  initial begin
    rst = 1'b0; dfp_addr = 32'h0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = 256'h0;
    bmem_ready = 1'b0; bmem_rdata = 64'h0; bmem_rvalid = 1'b0;
    tick();
    tick();
    chk("rst_resp", dfp_resp, 0);
    chk("rst_read", bmem_read, 0);
    chk("rst_write", bmem_write, 0);
    chk("rst_addr", bmem_addr, 0);
    chk("rst_wdata", bmem_wdata, 0);
    chk("rst_rdata", dfp_rdata, 0);
    rst = 1'b1;
    tick();

    // Ideal-memory writeback: beats lowest first, resp on 5th cycle.
    do_write("wr_basic", 32'h0000_1234, W1, -1, 0, 1'b0, 5, 256'h0);
    // Two ready-low cycles before beat 1 push resp back by 2.
    do_write("wr_stall", 32'h0000_2fff, W2, 1, 2, 1'b0, 7, 256'h0);
    // Fill with one idle gap: latency 1, A, B, gap, C, D.
    do_read("rd_gap", 32'h8000_0040, R1, 16'b0000_0000_0011_0110, 8, 256'h0);

    // Read and write together: write first, stray rvalid ignored, then read.
    dfp_read = 1'b1;
    do_write("wr_both", 32'h0000_0400, W3, -1, 0, 1'b1, 5, R1);
    do_read("rd_after_both", 32'h0000_0400, R2, 16'b0000_0000_0000_1111, 6, R1);

    // Back-to-back fills; first line stays visible until the second resp.
    do_read("rd_b2b_1", 32'h0000_0840, R3, 16'b0000_0000_0000_1111, 6, R2);
    do_read("rd_b2b_2", 32'h0000_089c, R4, 16'b0000_0000_0101_0101, 9, R3);

    // Reset held 3 cycles while beat 2 of a writeback is on the bus.
    dfp_write = 1'b1; dfp_addr = 32'h0000_3000; dfp_wdata = W1; bmem_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_mid_pre_beat2", bmem_wdata, 64'hfedcba9876543210);
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_mid_resp", dfp_resp, 0);
      chk("rst_mid_write", bmem_write, 0);
      chk("rst_mid_read", bmem_read, 0);
      chk("rst_mid_addr", bmem_addr, 0);
      chk("rst_mid_wdata", bmem_wdata, 0);
      chk("rst_mid_rdata", dfp_rdata, 0);
    end
    rst = 1'b1; dfp_write = 1'b0;
    tick();
    chk("rst_after_resp", dfp_resp, 0);
    chk("rst_after_write", bmem_write, 0);
    do_read("rd_after_rst", 32'h0000_5060, R1, 16'b0000_0000_0000_1111, 6, 256'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
